mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin scheduler that shares one port of the switch's true dual-port packet memory among NUM_REQ requesters, e.g. the ingress writers or the egress readers.
- Registers the winner's address, data and write enable onto the memory port.
- Returns a one-hot grant pulse to the winner.
- Routes the memory read data back with a per-requester valid strobe, aligned to the memory's one-cycle registered read latency.
- One instance sits in front of port A or port B of the memory.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- MEM_SIZE, 1024, memory depth in words; address width AW = $clog2(MEM_SIZE).
- DATA_WIDTH, 16, bits per memory word.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester access request; held until grant.
- we  input  NUM_REQ  per-requester write (1) / read (0) qualifier.
- addr  input  NUM_REQ*AW  packed addresses; requester i uses slice [i*AW +: AW].
- wdata  input  NUM_REQ*DATA_WIDTH  packed write data; slice [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  one-hot grant pulse, 1 cycle.
- rvalid  output  NUM_REQ  one-hot read-data-valid pulse, 1 cycle.
- rdata  output  DATA_WIDTH  read data; equals mem_q, meaningful only while some rvalid bit is high.
- mem_addr  output  AW  memory port address.
- mem_d  output  DATA_WIDTH  memory port write data.
- mem_we  output  1  memory port write enable.
- mem_q  input  DATA_WIDTH  memory port read data.

Behaviour:
- Reset (asynchronous, any time): gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_d=0, priority pointer=0. Any in-flight read is dropped; no rvalid is produced for it.
- Eligible set each cycle: eligible = req & ~gnt. A requester whose gnt is high this cycle cannot win at the next edge. This prevents a double grant while the requester drops or changes req.
- Arbitration at each posedge: search eligible starting at index ptr, wrapping modulo NUM_REQ. The first set bit k wins.
- On a win:
  - gnt <= onehot(k).
  - mem_addr <= addr[k], mem_d <= wdata[k], mem_we <= we[k].
  - ptr <= (k+1) mod NUM_REQ.
- No eligible requester: gnt <= 0, mem_we <= 0, mem_addr/mem_d hold their previous values, ptr unchanged.
- Timing, with requests sampled at edge T:
  - gnt and the memory command are valid during cycle T+1.
  - The memory samples the command at edge T+1.
  - mem_q is valid during cycle T+2.
  - For a read win, rvalid[k] is high in cycle T+2, via a one-cycle delay of (gnt & ~we_latched).
  - A write win produces no rvalid.
- Throughput: one access per cycle across requesters. A single requester asserting continuously is granted every other cycle.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,2,3,0… No requester waits more than NUM_REQ grants.
- Requester obligation: hold req, we, addr and wdata stable until gnt is seen. Deasserting req before grant withdraws the request; the arbiter never latches a request early.
- Simultaneous rvalid and a new gnt to the same requester is legal and must be supported (pipelined).
- Same-address hazards against the other memory port are not resolved here; that is the system's responsibility.

Test Plan:
- Reset then idle, req=0000 for 10 cycles -> gnt=0, rvalid=0, mem_we=0, mem_addr=0 throughout.
- Requester 2 writes addr 0x05A data 0xBEEF, then reads 0x05A -> write gnt[2] one cycle after req with mem_we=1, mem_addr=0x05A, mem_d=0xBEEF. The read grant then gives rvalid=0100 two cycles after its request edge with rdata=0xBEEF.
- req=1111 held continuously, all reads -> gnt sequence 0001,0010,0100,1000,0001. Each rvalid follows its gnt by exactly one cycle.
- Only requester 0 requests continuously -> gnt[0] toggles 1,0,1,0. Adding requester 3 fills the gaps: the alternation is 0001,1000.
- Priority pointer after a grant to 1, then req=1001 -> requester 3 is granted before requester 0.
- Assert reset in the cycle between a read gnt and its rvalid -> rvalid never asserts, ptr returns to 0. After release, req=1111 yields gnt=0001 first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port among NUM_REQ requesters
//   clk, reset                  : clock, asynchronous active-high reset
//   req, we, addr, wdata        : per-requester request, write qualifier, packed address and write data
//   gnt, rvalid, rdata          : one-hot grant pulse, one-hot read-valid pulse, read data
//   mem_addr, mem_d, mem_we     : registered memory port command
//   mem_q                       : memory read data (one-cycle registered latency)
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MEM_SIZE = 1024,
    parameter int DATA_WIDTH = 16,
    localparam int AW = $clog2(MEM_SIZE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*AW-1:0]         addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [AW-1:0]                 mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_d,
    output logic                          mem_we,
    input  logic [DATA_WIDTH-1:0]         mem_q
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]         ptr_q, ptr_d, win;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d, rvalid_q, rvalid_d, eligible;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  we_q, we_d, found;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NUM_REQ);
    endfunction

    always_comb begin
        // a requester holding gnt this cycle may still show req; masking it avoids a double grant
        eligible = req & ~gnt_q;
        found = 1'b0;
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[wrap(int'(ptr_q) + i)]) begin
                found = 1'b1;
                win = wrap(int'(ptr_q) + i);
            end
        end
        gnt_d = found ? NUM_REQ'(1) << win : '0;
        addr_d = found ? addr[int'(win)*AW +: AW] : addr_q;
        d_d = found ? wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH] : d_q;
        we_d = found && we[win];
        ptr_d = found ? wrap(int'(win) + 1) : ptr_q;
        // read data returns one cycle after the command is on the port
        rvalid_d = gnt_q & {NUM_REQ{~we_q}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            gnt_q <= '0;
            rvalid_q <= '0;
            addr_q <= '0;
            d_q <= '0;
            we_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            rvalid_q <= rvalid_d;
            addr_q <= addr_d;
            d_q <= d_d;
            we_q <= we_d;
        end
    end

    assign gnt = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata = mem_q;
    assign mem_addr = addr_q;
    assign mem_d = d_q;
    assign mem_we = we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int N = 4, MS = 1024, DW = 16, AW = 10;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] req, we, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0] rdata, mem_d, mem_q;
    logic [AW-1:0] mem_addr;
    logic mem_we;

    typedef struct {
        int          due;
        logic [N-1:0] oh;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    logic [DW-1:0] shadow [int];
    logic [DW-1:0] mem [MS];
    bit wr [MS];
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(N), .MEM_SIZE(MS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_d(mem_d),
        .mem_we(mem_we), .mem_q(mem_q)
    );

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {6'h2B, a} ^ 16'h0F0F;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_d;
            wr[mem_addr] <= 1'b1;
        end
        mem_q <= wr[mem_addr] ? mem[mem_addr] : fill(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] ev;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        ev = (sbq.size() > 0 && sbq[0].due == cyc) ? sbq[0].oh : '0;
        chk("rvalid", 32'(rvalid), 32'(ev));
        if (ev != '0) begin
            chk("rdata", 32'(rdata), 32'(sbq[0].data));
            void'(sbq.pop_front());
        end
    endtask

    task automatic expect_gnt(input logic [N-1:0] e);
        chk("gnt", 32'(gnt), 32'(e));
        for (int k = 0; k < N; k++) begin
            if (e[k]) begin
                logic [AW-1:0] a;
                logic [DW-1:0] v;
                a = addr[k*AW +: AW];
                if (we[k]) shadow[int'(a)] = wdata[k*DW +: DW];
                else begin
                    v = shadow.exists(int'(a)) ? shadow[int'(a)] : fill(a);
                    sbq.push_back('{cyc + 1, e, v});
                end
            end
        end
    endtask

    task automatic rq(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[k] = 1'b1;
        we[k] = w;
        addr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    initial begin
        logic [N-1:0] seq3 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [N-1:0] seq4 [8] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000,
                                   4'b1000, 4'b0001, 4'b1000, 4'b0001};
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_mem_we", 32'(mem_we), 0);
            chk("idle_mem_addr", 32'(mem_addr), 0);
        end
        rq(2, 1'b1, 10'h05A, 16'hBEEF);
        step();
        expect_gnt(4'b0100);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h05A);
        chk("wr_mem_d", 32'(mem_d), 32'hBEEF);
        rq(2, 1'b0, 10'h05A, 16'h0000);
        step();
        expect_gnt(4'b0000);
        chk("mask_mem_we", 32'(mem_we), 0);
        chk("hold_mem_addr", 32'(mem_addr), 32'h05A);
        step();
        expect_gnt(4'b0100);
        chk("rd_mem_we", 32'(mem_we), 0);
        req = '0;
        step();
        expect_gnt(4'b0000);
        reset = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) rq(i, 1'b0, 10'(10'h100 + i), 16'h0000);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_gnt(seq3[i]);
        end
        req = '0;
        step();
        expect_gnt(4'b0000);
        step();
        rq(0, 1'b0, 10'h100, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) rq(3, 1'b0, 10'h103, 16'h0000);
            step();
            expect_gnt(seq4[i]);
        end
        req = '0;
        step();
        expect_gnt(4'b0000);
        step();
        rq(1, 1'b0, 10'h101, 16'h0000);
        step();
        expect_gnt(4'b0010);
        req = '0;
        rq(0, 1'b0, 10'h100, 16'h0000);
        rq(3, 1'b0, 10'h103, 16'h0000);
        step();
        expect_gnt(4'b1000);
        step();
        expect_gnt(4'b0001);
        req = '0;
        step();
        expect_gnt(4'b0000);
        step();
        rq(2, 1'b0, 10'h102, 16'h0000);
        step();
        expect_gnt(4'b0100);
        req = '0;
        reset = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_mem_we", 32'(mem_we), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_mem_d", 32'(mem_d), 0);
        chk("arst_rvalid", 32'(rvalid), 0);
        sbq.delete();
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) rq(i, 1'b0, 10'(10'h100 + i), 16'h0000);
        step();
        expect_gnt(4'b0001);
        req = '0;
        step();
        expect_gnt(4'b0000);
        step();
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
